// File: rtl/fc_param_streamer.sv
// Parameter transmitter for the FC classifier head: unpacks PACK lanes per
// loader beat and streams weights, then biases, one parameter per cycle.
module fc_param_streamer #(
    parameter int WIDTH_P = 60,
    parameter int WIDTH_L = 20,
    parameter int PACK    = 3,
    parameter int SIZE_I  = 512,
    parameter int SIZE_O  = 1000
) (
    input  logic               i_sclk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_s_valid,
    output logic               o_s_ready,
    input  logic [WIDTH_P-1:0] i_s_data,
    output logic [1:0]         o_param_vld,
    output logic [WIDTH_P-1:0] o_param,
    output logic               o_busy,
    output logic               o_done
);

    localparam int N_W   = SIZE_I * SIZE_O;
    localparam int N_TOT = N_W + SIZE_O;
    localparam int CW    = $clog2(N_TOT + 1);
    localparam int IW    = (PACK > 1) ? $clog2(PACK) : 1;

    localparam logic [CW-1:0] CNT_W      = CW'(N_W);
    localparam logic [CW-1:0] CNT_W_LAST = CW'(N_W - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(N_TOT - 1);
    localparam logic [CW-1:0] CNT_END    = CW'(N_TOT);
    localparam logic [IW-1:0] IDX_LAST   = IW'(PACK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WEIGHT,
        S_BIAS,
        S_DONE
    } state_t;

    state_t             state;
    logic [WIDTH_P-1:0] buf_data;
    logic               buf_full;
    logic [IW-1:0]      idx;
    logic [CW-1:0]      cnt;

    logic [WIDTH_L-1:0] lane;
    logic               busy;
    logic               lane_end;
    logic               last_emit;
    logic               accept;

    assign busy      = (state == S_WEIGHT) || (state == S_BIAS);
    assign lane_end  = (idx == IDX_LAST);
    assign last_emit = buf_full && (cnt == CNT_LAST);

    // Reload is allowed on the last lane so beats flow back to back, but not
    // once the final parameter is leaving: the tail of that beat is discarded.
    assign o_s_ready = busy && (cnt != CNT_END) &&
                       (!buf_full || (lane_end && !last_emit));
    assign accept    = i_s_valid && o_s_ready && !i_abort;

    always_comb begin
        lane = '0;
        for (int k = 0; k < PACK; k++) begin
            if (idx == IW'(k)) begin
                lane = buf_data[k*WIDTH_L +: WIDTH_L];
            end
        end
    end

    // Phase strobes follow the global counter, so a beat that straddles the
    // weight/bias boundary switches strobe mid-beat without a bubble.
    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= S_IDLE;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            idx         <= '0;
            cnt         <= '0;
            o_param_vld <= 2'b00;
            o_param     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_param_vld <= 2'b00;
            o_param     <= '0;
            o_done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state    <= S_WEIGHT;
                        o_busy   <= 1'b1;
                        cnt      <= '0;
                        idx      <= '0;
                        buf_full <= 1'b0;
                    end
                end
                S_WEIGHT, S_BIAS: begin
                    if (i_abort) begin
                        state    <= S_IDLE;
                        o_busy   <= 1'b0;
                        cnt      <= '0;
                        idx      <= '0;
                        buf_full <= 1'b0;
                    end else if (buf_full) begin
                        o_param     <= {{(WIDTH_P-WIDTH_L){lane[WIDTH_L-1]}}, lane};
                        o_param_vld <= (cnt < CNT_W) ? 2'b01 : 2'b10;
                        cnt         <= cnt + 1'b1;
                        if (cnt == CNT_W_LAST) begin
                            state <= S_BIAS;
                        end
                        if (last_emit) begin
                            buf_full <= 1'b0;
                            idx      <= '0;
                        end else if (lane_end) begin
                            idx <= '0;
                            if (accept) begin
                                buf_data <= i_s_data;
                            end else begin
                                buf_full <= 1'b0;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (cnt == CNT_END) begin
                        state  <= S_DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else if (accept) begin
                        buf_data <= i_s_data;
                        buf_full <= 1'b1;
                        idx      <= '0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_param_streamer.sv
// Self-checking bench for fc_param_streamer: small 4x5 instance driven from a
// vector table, plus a default-size instance for a short smoke load.
module tb_fc_param_streamer;

    localparam int WP    = 60;
    localparam int WL    = 20;
    localparam int PK    = 3;
    localparam int SI    = 4;
    localparam int SO    = 5;
    localparam int NW    = SI * SO;
    localparam int NT    = NW + SO;
    localparam int NBEAT = 9;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort_s = 1'b0;
    logic          s_valid = 1'b0;
    logic [WP-1:0] s_data = '0;
    logic          s_ready;
    logic [1:0]    pvld;
    logic [WP-1:0] param;
    logic          busy;
    logic          done;

    logic          b_start = 1'b0;
    logic          b_abort = 1'b0;
    logic          b_valid = 1'b0;
    logic [WP-1:0] b_data = '0;
    logic          b_ready;
    logic [1:0]    b_vld;
    logic [WP-1:0] b_param;
    logic          b_busy;
    logic          b_done;

    always #5 clk = ~clk;

    fc_param_streamer #(
        .WIDTH_P(WP), .WIDTH_L(WL), .PACK(PK), .SIZE_I(SI), .SIZE_O(SO)
    ) dut (
        .i_sclk(clk), .i_rstn(rstn), .i_start(start), .i_abort(abort_s),
        .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
        .o_param_vld(pvld), .o_param(param), .o_busy(busy), .o_done(done)
    );

    fc_param_streamer dut_big (
        .i_sclk(clk), .i_rstn(rstn), .i_start(b_start), .i_abort(b_abort),
        .i_s_valid(b_valid), .o_s_ready(b_ready), .i_s_data(b_data),
        .o_param_vld(b_vld), .o_param(b_param), .o_busy(b_busy), .o_done(b_done)
    );

    typedef struct {
        logic [WL-1:0] lane;
        logic [WP-1:0] exp_param;
        logic [1:0]    exp_vld;
    } vec_t;

    vec_t          vec [NT];
    logic [WL-1:0] lanes [NBEAT*PK];
    int            n_vec = 0;
    int            n_bad = 0;

    logic [WP-1:0] cap_p[$];
    logic [1:0]    cap_v[$];
    int            cap_t[$];
    int            done_cnt;
    int            done_t;
    int            ready_late;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane values 1..25 map straight through; the optional overrides exercise
    // sign extension on both sides of the weight/bias boundary.
    task automatic fill_table(input bit with_neg);
        for (int i = 0; i < NT; i++) begin
            vec[i].lane      = WL'(i + 1);
            vec[i].exp_param = WP'(i + 1);
            vec[i].exp_vld   = (i < NW) ? 2'b01 : 2'b10;
        end
        if (with_neg) begin
            vec[4]  = '{20'hFFFFF, 60'hFFF_FFFF_FFFF_FFFF, 2'b01};
            vec[12] = '{20'h7FFFF, 60'h000_0000_0007_FFFF, 2'b01};
            vec[21] = '{20'h80000, 60'hFFF_FFFF_FFF8_0000, 2'b10};
        end
        for (int i = 0; i < NT; i++) lanes[i] = vec[i].lane;
        lanes[NT]     = 20'd26;
        lanes[NT + 1] = 20'd27;
    endtask

    function automatic logic [WP-1:0] pack_beat(input int b);
        logic [WP-1:0] r;
        r = '0;
        for (int k = 0; k < PK; k++) r[k*WL +: WL] = lanes[b*PK + k];
        return r;
    endfunction

    // One load: start pulse at cycle 0, optional ignored restart, optional
    // abort once abort_at params have been seen. Bounded by budget cycles.
    task automatic apply_stimulus(input int gap, input int abort_at, input int restart_at, input int budget);
        int beat;
        int abort_cyc;
        beat      = 0;
        abort_cyc = -1;
        cap_p.delete();
        cap_v.delete();
        cap_t.delete();
        done_cnt   = 0;
        done_t     = -1;
        ready_late = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (pvld != 2'b00) begin
                cap_p.push_back(param);
                cap_v.push_back(pvld);
                cap_t.push_back(cyc);
            end else begin
                check_output("param_zero_when_idle", param, 0);
            end
            check_output("strobe_exclusive", pvld == 2'b11, 0);
            if (done) begin
                done_cnt++;
                done_t = cyc;
            end
            if (beat >= NBEAT && s_ready) ready_late++;
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                check_output("abort_busy", busy, 0);
                check_output("abort_ready", s_ready, 0);
                check_output("abort_vld", pvld, 0);
            end
            start   = (cyc == 0) || (cyc == restart_at);
            abort_s = (abort_at >= 0) && (abort_cyc < 0) && (cap_p.size() == abort_at);
            if (abort_s) abort_cyc = cyc;
            s_valid = (cyc > 0) && ($urandom_range(0, 99) >= gap);
            s_data  = (beat < NBEAT) ? pack_beat(beat) : 60'hABC_DEF0_1234_5678;
            if (s_valid && s_ready && !abort_s && beat < NBEAT) beat++;
            if (done_cnt > 0 && cyc >= done_t + 2) break;
        end
        @(negedge clk);
        start   = 1'b0;
        abort_s = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic verify_load(input string tag, input bit timed);
        check_output({tag, "_count"}, cap_p.size(), NT);
        for (int i = 0; i < NT; i++) begin
            if (i < cap_p.size()) begin
                check_output($sformatf("%s_param%0d", tag, i), cap_p[i], vec[i].exp_param);
                check_output($sformatf("%s_vld%0d", tag, i), cap_v[i], vec[i].exp_vld);
                if (timed) check_output($sformatf("%s_cycle%0d", tag, i), cap_t[i], 3 + i);
            end
        end
        check_output({tag, "_done_pulses"}, done_cnt, 1);
        if (timed) check_output({tag, "_done_cycle"}, done_t, 3 + NT);
        else if (cap_t.size() > 0) check_output({tag, "_done_cycle"}, done_t, cap_t[cap_t.size()-1] + 1);
        check_output({tag, "_ready_after_last"}, ready_late, 0);
    endtask

    initial begin
        logic [WP-1:0] bcap[$];
        logic [1:0]    bcapv[$];
        int            bb;

        fill_table(1'b0);

        repeat (2) @(negedge clk);
        check_output("rst_vld", pvld, 0);
        check_output("rst_param", param, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_ready", s_ready, 0);
        check_output("rst_big_busy", b_busy, 0);
        rstn = 1'b1;
        s_valid = 1'b1;
        s_data  = pack_beat(0);
        repeat (2) @(negedge clk);
        check_output("idle_ready", s_ready, 0);
        check_output("idle_busy", busy, 0);
        s_valid = 1'b0;

        $display("[TB] basic load, continuous valid");
        apply_stimulus(0, -1, -1, 80);
        verify_load("basic", 1'b1);

        $display("[TB] signed lanes, 50%% valid gaps, ignored mid-load start");
        fill_table(1'b1);
        apply_stimulus(50, -1, 12, 400);
        verify_load("gaps", 1'b0);

        $display("[TB] abort after 7 params, then restart");
        fill_table(1'b0);
        apply_stimulus(0, 7, -1, 30);
        check_output("abort_count", cap_p.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < cap_p.size()) check_output($sformatf("abort_param%0d", i), cap_p[i], vec[i].exp_param);
        end
        check_output("abort_no_done", done_cnt, 0);
        apply_stimulus(0, -1, -1, 80);
        verify_load("restart", 1'b1);

        $display("[TB] async reset mid-load");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = pack_beat(0);
        repeat (5) @(negedge clk);
        check_output("midload_busy", busy, 1);
        #2 rstn = 1'b0;
        #1;
        check_output("arst_vld", pvld, 0);
        check_output("arst_param", param, 0);
        check_output("arst_busy", busy, 0);
        check_output("arst_done", done, 0);
        check_output("arst_ready", s_ready, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("post_rst_ready", s_ready, 0);
            check_output("post_rst_busy", busy, 0);
        end
        s_valid = 1'b0;
        apply_stimulus(0, -1, -1, 80);
        verify_load("after_reset", 1'b1);

        $display("[TB] default-size smoke load");
        bb = 0;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (b_vld != 2'b00) begin
                bcap.push_back(b_param);
                bcapv.push_back(b_vld);
            end
            if (bcap.size() >= 10) break;
            b_valid = 1'b1;
            b_data  = {WL'(3*bb + 3), WL'(3*bb + 2), WL'(3*bb + 1)};
            if (b_ready) bb++;
            @(negedge clk);
        end
        check_output("big_count", bcap.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < bcap.size()) begin
                check_output($sformatf("big_param%0d", i), bcap[i], i + 1);
                check_output($sformatf("big_vld%0d", i), bcapv[i], 2'b01);
            end
        end
        b_valid = 1'b0;
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        @(negedge clk);
        check_output("big_abort_busy", b_busy, 0);
        check_output("big_abort_done", b_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
